// File: rtl/cpu_pkg.sv
// =============================================================================
// cpu_pkg : register-file widths and the writeback entry type shared by the
//           writeback path and register_file.
// Revision : 1.0
// =============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// =============================================================================
// wb_fifo : load-result FIFO whose buffered entries can be invalidated by
//           destination address (kill_en/kill_addr) while they wait.
// Revision : 1.0
// =============================================================================
`default_nettype none

module wb_fifo #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_dest,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [ADDR_W-1:0] kill_addr,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_dest,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_next;
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head_valid = valid_q[rd_ptr];
    assign head_dest  = dest_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

    // A matching kill also covers the entry being written this cycle.
    always_comb begin
        valid_next = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && (dest_q[i] == kill_addr)) begin
                valid_next[i] = 1'b0;
            end
        end
        if (push) begin
            valid_next[wr_ptr] = push_valid & ~(kill_en && (push_dest == kill_addr));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            valid_q <= valid_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= push_dest;
            data_q[wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// =============================================================================
// wb_arbiter : merges ALU results and buffered load results onto the single
//              register-file write port. Optional macro: WB_R0_ZERO_EN.
// Revision : 1.0
// =============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic              fifo_empty;
    logic              fifo_full;
    logic              head_valid;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              pop;
    logic              push_valid;
    logic              kill_en;
    logic              win_we;
    logic [ADDR_W-1:0] win_dest;
    logic [DATA_W-1:0] win_data;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_next;

    assign ld_ready = ~fifo_full;
    assign push     = ld_valid & ld_ready;
    assign pop      = ~alu_valid & ~fifo_empty;

`ifdef WB_R0_ZERO_EN
    assign kill_en    = alu_valid & (alu_dest != '0);
    assign push_valid = (ld_dest != '0);
`else
    assign kill_en    = alu_valid;
    assign push_valid = 1'b1;
`endif

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_valid (push_valid),
        .push_dest  (ld_dest),
        .push_data  (ld_data),
        .pop        (pop),
        .kill_en    (kill_en),
        .kill_addr  (alu_dest),
        .head_valid (head_valid),
        .head_dest  (head_dest),
        .head_data  (head_data),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_comb begin
        win_we   = alu_valid;
        win_dest = alu_dest;
        win_data = alu_data;
        if (!alu_valid) begin
            win_we   = pop & head_valid;
            win_dest = head_dest;
            win_data = head_data;
        end
`ifdef WB_R0_ZERO_EN
        if (win_dest == '0) begin
            win_we = 1'b0;
        end
`endif
        // Counts only cycles in which a waiting load loses to the ALU.
        starve_next = starve_cnt;
        if (pop || fifo_empty) begin
            starve_next = '0;
        end else if (alu_valid) begin
            starve_next = starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            alu_stall  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            rf_we <= win_we;
            if (win_we) begin
                rf_waddr <= win_dest;
                rf_wdata <= win_data;
            end
            if (starve_next == SC_W'(STARVE_MAX)) begin
                alu_stall  <= 1'b1;
                starve_cnt <= '0;
            end else begin
                alu_stall  <= 1'b0;
                starve_cnt <= starve_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the CPU. It merges two result sources into the single write port of the register file: fixed-latency ALU results and handshaked load results from the memory stage. The block sits directly upstream of `register_file` and drives its write-enable, address and data. Load results are buffered in a small FIFO; ALU results always take the port. A starvation counter guarantees forward progress for loads, and same-destination collisions are resolved in favour of the younger ALU result.

## Interface
- `DATA_W`, 16, register data width
- `ADDR_W`, 3, register address width (8 registers)
- `DEPTH`, 2, load FIFO entries (power of two, ≥2)
- `STARVE_MAX`, 4, consecutive lost arbitrations before the ALU is stalled
---
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `alu_valid`  in  1  ALU result present this cycle; there is no ready, so it must be accepted
- `alu_dest`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_stall`  out  1  registered; requests that the ALU issue no result next cycle
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  FIFO not full (combinational from count)
- `ld_dest`  in  ADDR_W  load destination register
- `ld_data`  in  DATA_W  load data
- `rf_we`  out  1  registered register-file write enable
- `rf_waddr`  out  ADDR_W  registered write address
- `rf_wdata`  out  DATA_W  registered write data

## Operation
- **Load push.** A load is pushed when `ld_valid & ld_ready`. The entry holds {valid, dest, data}.
- **Arbitration, each cycle:**
  - If `alu_valid`, the ALU wins.
  - Otherwise the oldest FIFO entry wins, if the FIFO is non-empty.
- **Pop.** The winner is popped or consumed.
- **Killed entries.** A popped entry whose valid bit is cleared produces no write. It still frees its slot.
- **Kill rule.** On every cycle with `alu_valid`, every buffered entry with dest == `alu_dest` has its valid bit cleared.
  - This includes an entry pushed in the same cycle.
  - Justification: the ALU result is always younger in program order.
- **Starvation counter.**
  - Increments on each cycle where the FIFO is non-empty and the ALU wins.
  - Resets to 0 whenever a FIFO entry is popped, or the FIFO is empty.
  - When the count reaches `STARVE_MAX`, `alu_stall` asserts for exactly one cycle and the count clears.
  - `alu_valid` arriving while `alu_stall` is high is a protocol error. A bench assertion flags it, and the ALU still wins.
- **Simultaneous push and pop.** These are allowed in the same cycle. The count is unchanged.
- **Full FIFO.** `ld_ready` is 0 while the FIFO is full. A pop in the same cycle does not raise `ld_ready` combinationally, so there is no full-FIFO bypass.
- **Pointers.** Read and write pointers wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits.

## Timing
- **Latency.**
  - ALU input to `rf_we`: 1 cycle.
  - Load input to `rf_we`: at least 2 cycles (push, then pop, then the registered output).
- **Reset values.** `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `alu_stall`=0, FIFO empty, `ld_ready`=1, starvation count 0.
- **Reset mid-operation.** All buffered loads are discarded. No write is issued in the cycle after reset deasserts.
- **Register-file contract.** `register_file` samples its write port on the same rising edge as the rest of the design. The arbiter produces at most one write per cycle.

## Configuration
- **`WB_R0_ZERO_EN` defined:**
  - Any winner with dest == 0 produces `rf_we`=0 but is still consumed.
  - A push with `ld_dest`==0 is accepted and marked invalid at entry.
  - ALU writes to R0 never kill FIFO entries.
- **`WB_R0_ZERO_EN` undefined:** R0 is an ordinary register and the rules above do not apply.

## Structure
- **Package `cpu_pkg`** holds:
  - the `DATA_W` and `ADDR_W` constants shared with `register_file`;
  - the typedef `wb_entry_t` {valid, dest, data}.
- **Sub-module `wb_fifo`:** the parameterised FIFO with per-entry kill input (`kill_en`, `kill_addr`). The arbitration, starvation counter and output register live in `wb_arbiter`.

## Test plan
- **Reset:** `rst` is held high for 3 cycles with `ld_valid`=1. Required: all outputs hold reset values and `ld_ready`=1; after release, no `rf_we` pulse occurs unless input was given.
- **ALU only:** `alu_valid` with dest=3, data=0x1234. Required: the next cycle shows `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x1234.
- **Load buffering:**
  - Two loads (dest 1 = 0xAAAA, dest 2 = 0x5555) arrive in back-to-back cycles while the ALU is idle. Required: two in-order writes; `ld_ready` stays 1 with `DEPTH`=2 because of the concurrent pop.
  - `ld_valid` is then held for 3 cycles while the ALU is busy. Required: `ld_ready`=0 after 2 pushes.
- **Starvation:** the FIFO holds one load while `alu_valid`=1 continuously. Required:
  - `alu_stall` pulses exactly one cycle after 4 lost arbitrations;
  - the load writes in the stall cycle;
  - the counter restarts from 0.
- **Kill:** load dest=5 is buffered, then an ALU write to dest=5 occurs. Required: only the ALU write appears, and the load slot frees with no write.
- **R0:** with `WB_R0_ZERO_EN`, an ALU write to dest 0 gives `rf_we`=0. Without the macro, `rf_we`=1 and `rf_waddr`=0.
